// File: rtl/pc_sequencer_if.sv
// Command/status bundle between the instruction decoder and the PC sequencer.
interface pc_sequencer_if #(
  parameter int SIZE_LOG    = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int LW = $clog2(STACK_DEPTH + 1);

  logic                halt;
  logic                ret;
  logic                call;
  logic                write;
  logic                skip;
  logic                clear_err;
  logic [SIZE_LOG-1:0] address_in;
  logic [SIZE_LOG-1:0] address_out;
  logic [LW-1:0]       stack_level;
  logic                stack_empty;
  logic                stack_full;
  logic                overflow;
  logic                underflow;

  // Decoder side: drives strobes, observes PC and stack status
  modport master (
    output halt, ret, call, write, skip, clear_err, address_in,
    input  address_out, stack_level, stack_empty, stack_full, overflow, underflow
  );

  // Sequencer side
  modport slave (
    input  halt, ret, call, write, skip, clear_err, address_in,
    output address_out, stack_level, stack_empty, stack_full, overflow, underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-address sequencer: increment, jump, skip, call/ret with a hardware
// return stack, halt hold and sticky stack-error flags. State updates on the
// falling clock edge.
module pc_sequencer #(
  parameter int SIZE_LOG    = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic                clk,
  input  logic                rst,
  pc_sequencer_if.slave       bus
);
  localparam int LW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RET,
    ACT_CALL,
    ACT_WRITE,
    ACT_SKIP,
    ACT_INC
  } act_t;

  logic [SIZE_LOG-1:0] r_pc;
  logic [LW-1:0]       r_level;
  logic                r_ovf;
  logic                r_unf;
  logic [SIZE_LOG-1:0] r_stack [STACK_DEPTH];

  act_t                w_act;
  logic                w_empty;
  logic                w_full;
  logic [SIZE_LOG-1:0] w_pc_inc;
  logic [SIZE_LOG-1:0] w_pc_next;
  logic [LW-1:0]       w_level_next;
  logic                w_push;
  logic                w_ovf_set;
  logic                w_unf_set;
  logic                w_ovf_next;
  logic                w_unf_next;
  logic [IW-1:0]       w_wr_idx;
  logic [IW-1:0]       w_top_idx;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(STACK_DEPTH));
  assign w_pc_inc  = r_pc + SIZE_LOG'(1);
  // Index is only used when in range: push requires !full, pop requires !empty
  assign w_wr_idx  = IW'(r_level);
  assign w_top_idx = IW'(r_level - LW'(1));

  // Fixed-priority selection of the single action for this edge
  always_comb begin
    w_act = ACT_INC;
    if (bus.halt)       w_act = ACT_HOLD;
    else if (bus.ret)   w_act = ACT_RET;
    else if (bus.call)  w_act = ACT_CALL;
    else if (bus.write) w_act = ACT_WRITE;
    else if (bus.skip)  w_act = ACT_SKIP;
  end

  // Next PC, stack level, push strobe and error events for the selected action
  always_comb begin
    w_pc_next    = r_pc;
    w_level_next = r_level;
    w_push       = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    unique case (w_act)
      ACT_HOLD: ;
      ACT_RET: begin
        if (w_empty) begin
          w_pc_next = w_pc_inc;
          w_unf_set = 1'b1;
        end else begin
          w_pc_next    = r_stack[w_top_idx];
          w_level_next = r_level - LW'(1);
        end
      end
      ACT_CALL: begin
        if (w_full) begin
          w_pc_next = w_pc_inc;
          w_ovf_set = 1'b1;
        end else begin
          w_pc_next    = bus.address_in;
          w_level_next = r_level + LW'(1);
          w_push       = 1'b1;
        end
      end
      ACT_WRITE: w_pc_next = bus.address_in;
      ACT_SKIP:  w_pc_next = r_pc + SIZE_LOG'(2);
      default:   w_pc_next = w_pc_inc;
    endcase
  end

  // Sticky flags: clear_err acts even under halt, a new error on the same edge wins
  assign w_ovf_next = (r_ovf & ~bus.clear_err) | w_ovf_set;
  assign w_unf_next = (r_unf & ~bus.clear_err) | w_unf_set;

  // PC, level and flag registers with asynchronous reset
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= SIZE_LOG'(RESET_ADDR);
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_level <= w_level_next;
      r_ovf   <= w_ovf_next;
      r_unf   <= w_unf_next;
    end
  end

  // Return-stack storage; contents are don't-care after reset so no reset here
  always_ff @(negedge clk) begin
    if (!rst && w_push) r_stack[w_wr_idx] <= w_pc_inc;
  end

  assign bus.address_out = r_pc;
  assign bus.stack_level = r_level;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_unf;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-address sequencer that supersedes the plain increment/load program counter in the MC14500B control path. Beyond increment and absolute jump, it adds a hardware return-address stack for call and return, a skip-next-instruction step, a halt hold, and sticky stack-error flags. It sits between the instruction decoder, which drives the command strobes, and the program ROM, which is addressed by `address_out`.

## Interface
- `SIZE_LOG`, 8, address width in bits; PC range 0 .. 2^SIZE_LOG-1
- `STACK_DEPTH`, 4, return-stack entries, must be ≥1
- `RESET_ADDR`, 0, PC value on reset
- `clk`  in  1  system clock; all state updates on the falling edge
- `rst`  in  1  asynchronous, active-high reset
- `halt`  in  1  hold PC and stack unchanged
- `ret`  in  1  pop return address into PC
- `call`  in  1  push PC+1, load `address_in`
- `write`  in  1  jump: load `address_in`
- `skip`  in  1  advance PC by 2
- `clear_err`  in  1  clear sticky error flags
- `address_in`  in  SIZE_LOG  jump/call target
- `address_out`  out  SIZE_LOG  current PC, registered
- `stack_level`  out  $clog2(STACK_DEPTH+1)  occupied stack entries
- `stack_empty`  out  1  `stack_level`==0
- `stack_full`  out  1  `stack_level`==STACK_DEPTH
- `overflow`  out  1  sticky: call attempted while full
- `underflow`  out  1  sticky: ret attempted while empty

## Operation
- Exactly one action per falling edge. Fixed priority: halt > ret > call > write > skip > increment. Lower-priority strobes asserted at the same time are ignored.
- halt: PC, stack and flags are held. `clear_err` is still honoured.
- ret, stack not empty: PC ← top entry; level −1.
- ret, stack empty: PC ← PC+1; level stays 0; `underflow` ← 1.
- call, stack not full: entry[level] ← PC+1 (mod 2^SIZE_LOG); PC ← `address_in`; level +1.
- call, stack full: no push, no jump; PC ← PC+1; `overflow` ← 1; stack contents are unchanged.
- write: PC ← `address_in`; stack untouched.
- skip: PC ← PC+2 (mod 2^SIZE_LOG).
- Default: PC ← PC+1 (mod 2^SIZE_LOG).
- Arithmetic is modulo 2^SIZE_LOG with no carry out:
  - max+1 → 0
  - max+2 → 1
  - max−1 +2 → 0
- Stack is LIFO with a single write pointer equal to `stack_level`. Top entry = entry[level−1].
- `clear_err`:
  - Clears both sticky flags on the same edge.
  - If a new error occurs on that edge, set wins.
- `stack_empty` and `stack_full` are combinational decodes of `stack_level`.

## Timing
- Async reset, applied immediately without waiting for an edge:
  - `address_out` = RESET_ADDR
  - `stack_level` = 0, `stack_empty` = 1, `stack_full` = 0
  - `overflow` = 0, `underflow` = 0
- Stack entry contents after reset are don't-care.
- Reset asserted mid-call or mid-return aborts the operation and restores the full reset state above.
- First update after reset release happens on the first falling edge with `rst` low.
- Latency is one edge for every action: strobes sampled on a falling edge take effect on `address_out` immediately after that edge.
- `address_out` is always registered, never combinational from the inputs.
- Call immediately followed by ret (consecutive edges) returns to the caller's PC+1 with level restored.
- Back-to-back calls up to STACK_DEPTH all succeed. Call number STACK_DEPTH+1 raises `overflow`.
- Strobes are level-sampled; a strobe held for N edges acts N times.

## Test plan
- Reset and increment, wrap-around:
  - Reset; 3 idle edges → `address_out` 0,1,2,3.
  - `write`=1, `address_in`=0xFE; then 3 idle edges → FE, FF, 00, 01.
- Skip wrap: PC=0xFE, `skip` → 0x00. PC=0xFF, `skip` → 0x01.
- Nested call/ret, STACK_DEPTH=4:
  - At PC 0x10 call 0x40 → PC 0x40, level 1.
  - At 0x40 call 0x80 → PC 0x80, level 2.
  - ret → 0x41; ret → 0x11, level 0, `stack_empty` 1.
- Overflow and underflow:
  - 4 calls → `stack_full` 1.
  - 5th call from PC 0x20 → PC 0x21, level 4, `overflow` 1.
  - 4 rets restore the correct addresses.
  - 5th ret from PC 0x33 → PC 0x34, `underflow` 1.
  - `clear_err` → both flags 0.
- Priority and halt:
  - `halt`+`call`+`write` → PC and level unchanged.
  - `ret`+`call` with level 1 → pop only.
  - `write`+`skip` → loads `address_in`.
- Async reset mid-sequence: level 3, PC 0x55, `overflow` 1; assert `rst` between edges → all outputs return to reset values immediately, before the next edge.
